// File: rtl/player_mover.sv
// Grid player controller: direction hold with auto-repeat, edge bumps, stun, and bomb requests with cooldown.
// The FSM state is exported on state_debug so checkers can bind to it.
module player_mover #(
  parameter int GRID_W        = 16,
  parameter int GRID_H        = 16,
  parameter int START_X       = 0,
  parameter int START_Y       = 0,
  parameter int REPEAT_TICKS  = 4,
  parameter int STUN_TICKS    = 8,
  parameter int BOMB_COOLDOWN = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       directionLeft,
  input  logic       directionRight,
  input  logic       directionUp,
  input  logic       directionDown,
  input  logic       bombEnable,
  input  logic       stunnedEffect,
  output logic [5:0] positionX,
  output logic [5:0] positionY,
  output logic [1:0] facing,
  output logic       stunActive,
  output logic       bombRequested,
  output logic [3:0] animationAction,
  output logic [1:0] state_debug
);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, STUNNED = 2'd2} state_t;

  localparam logic [1:0]  DIR_LEFT  = 2'd0;
  localparam logic [1:0]  DIR_RIGHT = 2'd1;
  localparam logic [1:0]  DIR_UP    = 2'd2;
  localparam logic [1:0]  DIR_DOWN  = 2'd3;
  localparam logic [5:0]  MAX_X     = 6'(GRID_W - 1);
  localparam logic [5:0]  MAX_Y     = 6'(GRID_H - 1);
  localparam logic [5:0]  INIT_X    = 6'(START_X);
  localparam logic [5:0]  INIT_Y    = 6'(START_Y);
  localparam logic [15:0] REP_LOAD  = 16'(REPEAT_TICKS);
  localparam logic [15:0] STUN_LOAD = 16'(STUN_TICKS);
  localparam logic [15:0] BOMB_LOAD = 16'(BOMB_COOLDOWN);

  state_t      state, state_n;
  logic [1:0]  held, held_n;
  logic [15:0] rep_cnt, rep_n;
  logic [15:0] stun_cnt, stun_n;
  logic [15:0] bomb_cd;
  logic        bomb_prev;
  logic        bump_q;
  logic        do_step;
  logic        any_dir;
  logic [1:0]  act_dir;
  logic        hit_edge;
  logic        bomb_fire;

  // Up > Down > Left > Right
  assign any_dir = directionUp | directionDown | directionLeft | directionRight;
  assign act_dir = directionUp   ? DIR_UP   :
                   directionDown ? DIR_DOWN :
                   directionLeft ? DIR_LEFT : DIR_RIGHT;

  always_comb begin
    hit_edge = 1'b0;
    case (act_dir)
      DIR_LEFT:  hit_edge = (positionX == 6'd0);
      DIR_RIGHT: hit_edge = (positionX == MAX_X);
      DIR_UP:    hit_edge = (positionY == MAX_Y);
      default:   hit_edge = (positionY == 6'd0);
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      held     <= DIR_DOWN;
      rep_cnt  <= '0;
      stun_cnt <= '0;
    end else begin
      state    <= state_n;
      held     <= held_n;
      rep_cnt  <= rep_n;
      stun_cnt <= stun_n;
    end
  end

  // Stun overrides everything, including a step due on the same cycle.
  always_comb begin
    state_n = state;
    held_n  = held;
    rep_n   = rep_cnt;
    stun_n  = stun_cnt;
    do_step = 1'b0;
    if (stunnedEffect) begin
      state_n = STUNNED;
      stun_n  = STUN_LOAD;
      rep_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick && any_dir) begin
            do_step = 1'b1;
            rep_n   = REP_LOAD;
            held_n  = act_dir;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (!any_dir) begin
            state_n = IDLE;
            rep_n   = '0;
          end else if (tick) begin
            if (act_dir != held) begin
              do_step = 1'b1;
              rep_n   = REP_LOAD;
              held_n  = act_dir;
            end else if (rep_cnt <= 16'd1) begin
              do_step = 1'b1;
              rep_n   = REP_LOAD;
            end else begin
              rep_n   = rep_cnt - 16'd1;
            end
          end
        end
        STUNNED: begin
          if (tick) begin
            if (stun_cnt <= 16'd1) begin
              stun_n  = '0;
              state_n = IDLE;
            end else begin
              stun_n  = stun_cnt - 16'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bomb_fire = bombEnable && !bomb_prev && (state != STUNNED) && (bomb_cd == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      positionX     <= INIT_X;
      positionY     <= INIT_Y;
      facing        <= DIR_DOWN;
      bump_q        <= 1'b0;
      bomb_prev     <= 1'b0;
      bombRequested <= 1'b0;
      bomb_cd       <= '0;
    end else begin
      bump_q <= do_step && hit_edge;
      if (do_step) begin
        facing <= act_dir;
        if (!hit_edge) begin
          case (act_dir)
            DIR_LEFT:  positionX <= positionX - 6'd1;
            DIR_RIGHT: positionX <= positionX + 6'd1;
            DIR_UP:    positionY <= positionY + 6'd1;
            default:   positionY <= positionY - 6'd1;
          endcase
        end
      end
      bomb_prev     <= bombEnable;
      bombRequested <= bomb_fire;
      if (bomb_fire)
        bomb_cd <= BOMB_LOAD;
      else if (tick && (bomb_cd != '0))
        bomb_cd <= bomb_cd - 16'd1;
    end
  end

  always_comb begin
    stunActive      = (state == STUNNED);
    state_debug     = state;
    animationAction = 4'd0;
    if (state == STUNNED)
      animationAction = 4'd5;
    else if (bombRequested)
      animationAction = 4'd7;
    else if (bump_q)
      animationAction = 4'd6;
    else if (state == HOLD)
      animationAction = {2'b00, held} + 4'd1;
  end

endmodule
